modulator_ctrl: RTL and testbench

Control and sequencing block for the PWM `modulator`. It debounces the raw frequency-select switch and drives the modulator's `sw0` select. It also holds the high and low division factors in runtime-writable shadow registers. Every change to select or divisors is applied only at a PWM period boundary, so the modulator never sees a mid-period reconfiguration.

---
 rtl/modulator_ctrl.sv | 153 +++++++++++++++
 tb/tb_modulator_ctrl.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/modulator_ctrl.sv
// Control/sequencing for the PWM modulator: debounced frequency-select switch and
// shadowed divisor registers, with all changes committed only at a period boundary.
module modulator_ctrl #(
   parameter int unsigned             div_width_p     = 32,
   parameter logic [div_width_p-1:0]  div_high_init_p = 12288,
   parameter logic [div_width_p-1:0]  div_low_init_p  = 40960,
   parameter logic                    init_sel_p      = 1'b1,
   parameter int unsigned             debounce_p      = 16,
   parameter int unsigned             dwell_p         = 4
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   sw0_in,
   input  logic                   period_end_in,
   input  logic                   cfg_we_in,
   input  logic                   cfg_sel_in,
   input  logic [div_width_p-1:0] cfg_data_in,
   output logic                   cfg_ack_out,
   output logic                   sel_out,
   output logic [div_width_p-1:0] div_high_out,
   output logic [div_width_p-1:0] div_low_out,
   output logic                   pending_out
);

   localparam int unsigned DBW = (debounce_p > 1) ? $clog2(debounce_p) : 1;
   localparam int unsigned DWW = (dwell_p > 1) ? $clog2(dwell_p) : 1;
   localparam logic [DBW-1:0] DEB_MAX  = DBW'(debounce_p - 1);
   localparam logic [DWW-1:0] DWELL_LD = DWW'(dwell_p - 1);

   typedef enum logic [1:0] {IDLE, PEND, HOLD} state_t;

   logic                   sync1_q, sync2_q;
   logic                   stable_q, stable_d;
   logic [DBW-1:0]         deb_cnt_q, deb_cnt_d;
   state_t                 state_q, state_d;
   logic [DWW-1:0]         dwell_q, dwell_d;
   logic                   sel_q, sel_d;
   logic [div_width_p-1:0] shadow_high_q, shadow_high_d;
   logic [div_width_p-1:0] shadow_low_q, shadow_low_d;
   logic                   dirty_high_q, dirty_high_d;
   logic                   dirty_low_q, dirty_low_d;
   logic [div_width_p-1:0] div_high_q, div_high_d;
   logic [div_width_p-1:0] div_low_q, div_low_d;
   logic                   ack_q;
   logic                   pending_q, pending_d;

   always_comb begin
      stable_d  = stable_q;
      deb_cnt_d = '0;
      if (sync2_q != stable_q) begin
         if (deb_cnt_q == DEB_MAX) begin
            stable_d = sync2_q;
         end else begin
            deb_cnt_d = deb_cnt_q + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      dwell_d = dwell_q;
      sel_d   = sel_q;
      unique case (state_q)
         IDLE: begin
            if (stable_q != sel_q) state_d = PEND;
         end
         PEND: begin
            // Cancel wins over a coincident boundary.
            if (stable_q == sel_q) begin
               state_d = IDLE;
            end else if (period_end_in) begin
               sel_d   = stable_q;
               dwell_d = DWELL_LD;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (dwell_q == '0) state_d = IDLE;
            else               dwell_d = dwell_q - 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      shadow_high_d = shadow_high_q;
      shadow_low_d  = shadow_low_q;
      dirty_high_d  = dirty_high_q;
      dirty_low_d   = dirty_low_q;
      div_high_d    = div_high_q;
      div_low_d     = div_low_q;
      // Commit uses the pre-write shadow; a coincident write re-marks dirty below.
      if (period_end_in) begin
         if (dirty_high_q) div_high_d = shadow_high_q;
         if (dirty_low_q)  div_low_d  = shadow_low_q;
         dirty_high_d = 1'b0;
         dirty_low_d  = 1'b0;
      end
      if (cfg_we_in) begin
         if (cfg_sel_in) begin
            shadow_high_d = cfg_data_in;
            dirty_high_d  = 1'b1;
         end else begin
            shadow_low_d = cfg_data_in;
            dirty_low_d  = 1'b1;
         end
      end
      pending_d = (state_d == PEND) | dirty_high_d | dirty_low_d;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync1_q       <= init_sel_p;
         sync2_q       <= init_sel_p;
         stable_q      <= init_sel_p;
         deb_cnt_q     <= '0;
         state_q       <= IDLE;
         dwell_q       <= '0;
         sel_q         <= init_sel_p;
         shadow_high_q <= div_high_init_p;
         shadow_low_q  <= div_low_init_p;
         dirty_high_q  <= 1'b0;
         dirty_low_q   <= 1'b0;
         div_high_q    <= div_high_init_p;
         div_low_q     <= div_low_init_p;
         ack_q         <= 1'b0;
         pending_q     <= 1'b0;
      end else begin
         sync1_q       <= sw0_in;
         sync2_q       <= sync1_q;
         stable_q      <= stable_d;
         deb_cnt_q     <= deb_cnt_d;
         state_q       <= state_d;
         dwell_q       <= dwell_d;
         sel_q         <= sel_d;
         shadow_high_q <= shadow_high_d;
         shadow_low_q  <= shadow_low_d;
         dirty_high_q  <= dirty_high_d;
         dirty_low_q   <= dirty_low_d;
         div_high_q    <= div_high_d;
         div_low_q     <= div_low_d;
         ack_q         <= cfg_we_in;
         pending_q     <= pending_d;
      end
   end

   assign cfg_ack_out  = ack_q;
   assign sel_out      = sel_q;
   assign div_high_out = div_high_q;
   assign div_low_out  = div_low_q;
   assign pending_out  = pending_q;

endmodule

// File: tb/tb_modulator_ctrl.sv
// Directed self-checking bench for modulator_ctrl; inputs driven and outputs
// sampled on the falling clock edge.
module tb_modulator_ctrl;

   logic        clk_in = 1'b0;
   logic        rst_in;
   logic        sw0_in;
   logic        period_end_in;
   logic        cfg_we_in;
   logic        cfg_sel_in;
   logic [31:0] cfg_data_in;
   logic        cfg_ack_out;
   logic        sel_out;
   logic [31:0] div_high_out;
   logic [31:0] div_low_out;
   logic        pending_out;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   modulator_ctrl #(
      .div_width_p     (32),
      .div_high_init_p (32'd12288),
      .div_low_init_p  (32'd40960),
      .init_sel_p      (1'b1),
      .debounce_p      (16),
      .dwell_p         (4)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .sw0_in        (sw0_in),
      .period_end_in (period_end_in),
      .cfg_we_in     (cfg_we_in),
      .cfg_sel_in    (cfg_sel_in),
      .cfg_data_in   (cfg_data_in),
      .cfg_ack_out   (cfg_ack_out),
      .sel_out       (sel_out),
      .div_high_out  (div_high_out),
      .div_low_out   (div_low_out),
      .pending_out   (pending_out)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int unsigned n);
      repeat (n) @(negedge clk_in);
   endtask

   task automatic boundary();
      period_end_in = 1'b1;
      tick(1);
      period_end_in = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_sel"},  32'(sel_out),     32'd1);
      check({tag, "_high"}, div_high_out,     32'd12288);
      check({tag, "_low"},  div_low_out,      32'd40960);
      check({tag, "_pend"}, 32'(pending_out), 32'd0);
      check({tag, "_ack"},  32'(cfg_ack_out), 32'd0);
   endtask

   logic seen_pend;

   initial begin
      rst_in = 1'b1; sw0_in = 1'b1; period_end_in = 1'b0;
      cfg_we_in = 1'b0; cfg_sel_in = 1'b0; cfg_data_in = '0;
      tick(3);
      rst_in = 1'b0;
      tick(1);
      check_reset_vals("reset");

      // Glitch of 10 cycles must be filtered out.
      sw0_in = 1'b0;
      tick(10);
      sw0_in = 1'b1;
      seen_pend = 1'b0;
      for (int i = 0; i < 30; i++) begin
         tick(1);
         seen_pend = seen_pend | pending_out;
      end
      check("glitch_pend", 32'(seen_pend), 32'd0);
      check("glitch_sel",  32'(sel_out),   32'd1);

      // Request reaches PEND, then switch returns before any boundary.
      sw0_in = 1'b0;
      tick(19);
      check("cancel_pend_hi", 32'(pending_out), 32'd1);
      sw0_in = 1'b1;
      tick(25);
      check("cancel_pend_lo", 32'(pending_out), 32'd0);
      boundary();
      check("cancel_sel", 32'(sel_out), 32'd1);
      tick(5);

      // Accepted switch: PEND entered 18 edges after the sampling edge.
      sw0_in = 1'b0;
      tick(18);
      check("sw_pend_pre", 32'(pending_out), 32'd0);
      tick(1);
      check("sw_pend_on",  32'(pending_out), 32'd1);
      tick(20);
      check("sw_pend_hold", 32'(pending_out), 32'd1);
      check("sw_sel_pre",   32'(sel_out),     32'd1);
      boundary();
      check("sw_sel_post",  32'(sel_out),     32'd0);
      check("sw_pend_post", 32'(pending_out), 32'd0);
      tick(10);
      check("sw_idle_pend", 32'(pending_out), 32'd0);

      // Back-to-back divisor writes.
      cfg_we_in = 1'b1; cfg_sel_in = 1'b1; cfg_data_in = 32'd20000;
      tick(1);
      check("wr_ack1", 32'(cfg_ack_out), 32'd1);
      cfg_sel_in = 1'b0; cfg_data_in = 32'd50000;
      tick(1);
      cfg_we_in = 1'b0;
      check("wr_ack2",  32'(cfg_ack_out), 32'd1);
      check("wr_pend",  32'(pending_out), 32'd1);
      check("wr_high0", div_high_out,     32'd12288);
      check("wr_low0",  div_low_out,      32'd40960);
      tick(1);
      check("wr_ack_off", 32'(cfg_ack_out), 32'd0);
      tick(3);
      check("wr_high1", div_high_out, 32'd12288);
      boundary();
      check("wr_high2", div_high_out,     32'd20000);
      check("wr_low2",  div_low_out,      32'd50000);
      check("wr_pend2", 32'(pending_out), 32'd0);

      // Write coincident with boundary commits one boundary later.
      cfg_we_in = 1'b1; cfg_sel_in = 1'b1; cfg_data_in = 32'd30000;
      period_end_in = 1'b1;
      tick(1);
      cfg_we_in = 1'b0; period_end_in = 1'b0;
      check("coinc_high", div_high_out,     32'd20000);
      check("coinc_pend", 32'(pending_out), 32'd1);
      check("coinc_ack",  32'(cfg_ack_out), 32'd1);
      tick(3);
      boundary();
      check("coinc_high2", div_high_out,     32'd30000);
      check("coinc_pend2", 32'(pending_out), 32'd0);

      // Async reset while in PEND with a dirty shadow.
      sw0_in = 1'b1;
      tick(19);
      check("rst_pend_pre", 32'(pending_out), 32'd1);
      check("rst_sel_pre",  32'(sel_out),     32'd0);
      cfg_we_in = 1'b1; cfg_sel_in = 1'b0; cfg_data_in = 32'd777;
      tick(1);
      cfg_we_in = 1'b0;
      #2 rst_in = 1'b1;
      #1 check_reset_vals("async_rst");
      tick(1);
      rst_in = 1'b0;
      tick(2);
      boundary();
      tick(1);
      check_reset_vals("post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
